// File: rtl/uart_tx_ctrl.sv
// UART transmit frame sequencer: walks start, data (LSB first), optional parity
// and stop phases, driving the TX mux select plus the serial data and parity bits.
module uart_tx_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE_W = 6
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [1:0]            mux_sel,
  output logic                  ser_data,
  output logic                  par_bit,
  output logic                  busy,
  output logic [2:0]            fsm_state
);

  // Handshake: DATA_VALID is level-sampled with no ready; it is accepted only in
  // IDLE or on the final STOP cycle, and busy=1 means any other strobe is ignored.

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

  localparam logic [1:0] SEL_START  = 2'b00;
  localparam logic [1:0] SEL_IDLE   = 2'b01;
  localparam logic [1:0] SEL_DATA   = 2'b10;
  localparam logic [1:0] SEL_PARITY = 2'b11;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [DATA_WIDTH-1:0] shift_reg, shift_n, shifted;
  logic [CNT_W-1:0]      bit_cnt, bit_cnt_n;
  logic [PRESCALE_W-1:0] pre_cnt, pre_cnt_n;
  logic [PRESCALE_W-1:0] pre_lat, pre_lat_n;
  logic                  par_en_lat, par_en_n;
  logic                  ser_n, par_n, busy_n;
  logic [1:0]            mux_n;
  logic                  bit_end, do_load;

  assign bit_end   = (pre_cnt == pre_lat - 1'b1);
  assign fsm_state = state;

  always_comb begin
    state_n   = state;
    shift_n   = shift_reg;
    shifted   = shift_reg >> 1;
    bit_cnt_n = bit_cnt;
    pre_cnt_n = pre_cnt;
    pre_lat_n = pre_lat;
    par_en_n  = par_en_lat;
    ser_n     = ser_data;
    par_n     = par_bit;
    do_load   = 1'b0;
    mux_n     = SEL_IDLE;
    busy_n    = 1'b0;

    case (state)
      IDLE: begin
        if (DATA_VALID) do_load = 1'b1;
      end
      START: begin
        if (bit_end) begin
          pre_cnt_n = '0;
          bit_cnt_n = '0;
          ser_n     = shift_reg[0];
          state_n   = DATA;
        end else begin
          pre_cnt_n = pre_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bit_end) begin
          pre_cnt_n = '0;
          if (bit_cnt == LAST_BIT) begin
            state_n = par_en_lat ? PARITY : STOP;
          end else begin
            shift_n   = shifted;
            ser_n     = shifted[0];
            bit_cnt_n = bit_cnt + 1'b1;
          end
        end else begin
          pre_cnt_n = pre_cnt + 1'b1;
        end
      end
      PARITY: begin
        if (bit_end) begin
          pre_cnt_n = '0;
          state_n   = STOP;
        end else begin
          pre_cnt_n = pre_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bit_end) begin
          pre_cnt_n = '0;
          // Back-to-back frames skip IDLE so the line never idles between them.
          if (DATA_VALID) do_load = 1'b1;
          else            state_n = IDLE;
        end else begin
          pre_cnt_n = pre_cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase

    if (do_load) begin
      shift_n   = P_DATA;
      par_en_n  = PAR_EN;
      pre_lat_n = (prescale == '0) ? PRESCALE_W'(1) : prescale;
      par_n     = (^P_DATA) ^ PAR_TYP;
      pre_cnt_n = '0;
      bit_cnt_n = '0;
      state_n   = START;
    end

    // Outputs are registered, so they are decoded from the next state.
    case (state_n)
      START:   mux_n = SEL_START;
      DATA:    mux_n = SEL_DATA;
      PARITY:  mux_n = SEL_PARITY;
      default: mux_n = SEL_IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state      <= IDLE;
      shift_reg  <= '0;
      bit_cnt    <= '0;
      pre_cnt    <= '0;
      pre_lat    <= PRESCALE_W'(1);
      par_en_lat <= 1'b0;
      ser_data   <= 1'b0;
      par_bit    <= 1'b0;
      mux_sel    <= SEL_IDLE;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shift_reg  <= shift_n;
      bit_cnt    <= bit_cnt_n;
      pre_cnt    <= pre_cnt_n;
      pre_lat    <= pre_lat_n;
      par_en_lat <= par_en_n;
      ser_data   <= ser_n;
      par_bit    <= par_n;
      mux_sel    <= mux_n;
      busy       <= busy_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: per-cycle mux_sel scoreboard, data-bit and
// parity checks, back-to-back frames, mid-frame reset and prescale=0 handling.
module tb_uart_tx_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [7:0] P_DATA = '0;
  logic       DATA_VALID = 1'b0;
  logic       PAR_EN = 1'b0;
  logic       PAR_TYP = 1'b0;
  logic [5:0] prescale = '0;
  logic [1:0] mux_sel;
  logic       ser_data, par_bit, busy;
  logic [2:0] fsm_state;

  int n_checks = 0;
  int n_fails  = 0;
  logic [1:0] exp_q[$];

  uart_tx_ctrl #(.DATA_WIDTH(8), .PRESCALE_W(6)) dut (
    .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .DATA_VALID(DATA_VALID),
    .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .prescale(prescale),
    .mux_sel(mux_sel), .ser_data(ser_data), .par_bit(par_bit),
    .busy(busy), .fsm_state(fsm_state)
  );

  // clock / watchdog
  always #5 CLK = ~CLK;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h required %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one frame request; returns one cycle after the strobe is sampled.
  task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic [5:0] ps);
    P_DATA = d; PAR_EN = pe; PAR_TYP = pt; prescale = ps; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    DATA_VALID = 1'b0;
  endtask

  // Walk a frame already started; n = effective clocks per bit.
  task automatic expect_frame(input logic [7:0] d, input logic pe, input logic exp_par,
                              input int n, input bit toggle, input bit keep_dv);
    int total;
    logic [1:0] exp_sel;
    exp_q.delete();
    for (int k = 0; k < n; k++) exp_q.push_back(2'b00);
    for (int k = 0; k < 8 * n; k++) exp_q.push_back(2'b10);
    if (pe) for (int k = 0; k < n; k++) exp_q.push_back(2'b11);
    for (int k = 0; k < n; k++) exp_q.push_back(2'b01);
    total = exp_q.size();
    for (int i = 0; i < total; i++) begin
      @(negedge CLK);
      exp_sel = exp_q.pop_front();
      check_eq("mux_sel", mux_sel, exp_sel);
      check_eq("busy", busy, 1);
      check_eq("par_bit", par_bit, exp_par);
      if (exp_sel == 2'b10) check_eq("ser_data", ser_data, d[(i - n) / n]);
      if (keep_dv) begin
        DATA_VALID = 1'b1;
      end else if (toggle && i < total - n) begin
        DATA_VALID = 1'($urandom_range(0, 1));
        P_DATA     = 8'($urandom_range(0, 255));
        PAR_EN     = 1'($urandom_range(0, 1));
        PAR_TYP    = 1'($urandom_range(0, 1));
        prescale   = 6'($urandom_range(0, 63));
      end else begin
        DATA_VALID = 1'b0;
      end
      @(posedge CLK); #1;
    end
    if (!keep_dv) begin
      @(negedge CLK);
      check_eq("idle_mux_sel", mux_sel, 2'b01);
      check_eq("idle_busy", busy, 0);
      @(posedge CLK); #1;
    end
  endtask

  initial begin
    // reset
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    @(negedge CLK);
    check_eq("rst_mux_sel", mux_sel, 2'b01);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ser_data", ser_data, 0);
    check_eq("rst_par_bit", par_bit, 0);
    check_eq("rst_state", fsm_state, 0);
    @(posedge CLK); #1;
    RST = 1'b1;
    @(posedge CLK); #1;

    // 1: 0xA5 even parity, prescale 1
    send(8'hA5, 1'b1, 1'b0, 6'd1);
    expect_frame(8'hA5, 1'b1, 1'b0, 1, 1'b0, 1'b0);

    // 2: 0x00 odd parity
    send(8'h00, 1'b1, 1'b1, 6'd1);
    expect_frame(8'h00, 1'b1, 1'b1, 1, 1'b0, 1'b0);

    // 3: prescale 4, no parity, inputs toggled mid-frame
    send(8'h3C, 1'b0, 1'b0, 6'd4);
    expect_frame(8'h3C, 1'b0, 1'b0, 4, 1'b1, 1'b0);

    // 4: back-to-back with DATA_VALID held high
    P_DATA = 8'h01; PAR_EN = 1'b0; PAR_TYP = 1'b0; prescale = 6'd2; DATA_VALID = 1'b1;
    @(posedge CLK); #1;
    P_DATA = 8'h80;
    expect_frame(8'h01, 1'b0, 1'b1, 2, 1'b0, 1'b1);
    DATA_VALID = 1'b0;
    expect_frame(8'h80, 1'b0, 1'b1, 2, 1'b0, 1'b0);

    // 5: reset in DATA bit 3 of a prescale 3 frame
    send(8'h5A, 1'b1, 1'b1, 6'd3);
    repeat (13) @(posedge CLK);
    #1;
    @(negedge CLK);
    check_eq("pre_rst_mux_sel", mux_sel, 2'b10);
    check_eq("pre_rst_ser_data", ser_data, 1);
    check_eq("pre_rst_par_bit", par_bit, 1);
    RST = 1'b0;
    @(posedge CLK); #1;
    check_eq("abort_mux_sel", mux_sel, 2'b01);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_par_bit", par_bit, 0);
    check_eq("abort_state", fsm_state, 0);
    RST = 1'b1;
    @(posedge CLK); #1;
    send(8'h5A, 1'b1, 1'b0, 6'd3);
    expect_frame(8'h5A, 1'b1, 1'b0, 3, 1'b0, 1'b0);

    // 6: prescale 0 behaves as 1
    send(8'hC3, 1'b1, 1'b1, 6'd0);
    expect_frame(8'hC3, 1'b1, 1'b1, 1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/uart_tx_ctrl.md
Name: uart_tx_ctrl

Overview:
Frame sequencer for the UART transmit path. It accepts a parallel byte with a valid strobe and drives the transmit output mux select through the start, data, optional parity and stop bit phases. It also supplies the serial data bit and the parity bit that feed the mux. Bit timing comes from a programmable clocks-per-bit prescaler, and a busy flag is reported to the upstream system controller.

Parameters:
DATA_WIDTH, 8, number of data bits per frame, sent LSB first
PRESCALE_W, 6, width of the clocks-per-bit prescale input

Ports:
CLK  input  1  system clock, all logic on rising edge
RST  input  1  reset, synchronous, active-low
P_DATA  input  DATA_WIDTH  parallel data to transmit
DATA_VALID  input  1  P_DATA valid strobe, level-sampled
PAR_EN  input  1  1 = parity bit inserted after data bits
PAR_TYP  input  1  0 = even parity, 1 = odd parity
prescale  input  PRESCALE_W  CLK cycles per bit; 0 treated as 1
mux_sel  output  2  to TX mux: 00 start (0), 01 idle/stop (1), 10 serial data, 11 parity
ser_data  output  1  current data bit, to mux input ser_data
par_bit  output  1  frame parity bit, to mux input par_bit
busy  output  1  frame in progress

Behaviour:
- All outputs are registered. Reset (RST=0 at a clock edge) forces: state IDLE, mux_sel=01, ser_data=0, par_bit=0, busy=0, bit and prescale counters 0.
- Reset mid-frame abandons the frame. The line returns to idle-high (mux_sel=01) on the same edge.
- States: IDLE, START, DATA, PARITY, STOP.
- IDLE: mux_sel=01, busy=0.
  - If DATA_VALID=1 at an edge, latch P_DATA into the shift register, plus PAR_EN, PAR_TYP and prescale (0 stored as 1).
  - On the same edge, par_bit = (^P_DATA) XOR PAR_TYP.
  - Next state is START.
  - Latency: mux_sel=00 and busy=1 are visible one cycle after DATA_VALID is sampled.
- Bit period: each of START, DATA bit, PARITY and STOP lasts exactly the latched prescale count of cycles. The prescale counter runs 0..prescale-1; a bit ends when the counter equals prescale-1.
- START: mux_sel=00. At end of bit, go to DATA with bit counter 0 and ser_data = shift_reg[0].
- DATA: mux_sel=10.
  - At each end of bit, shift right and present the next bit on ser_data; bit counter increments.
  - After bit DATA_WIDTH-1 ends, go to PARITY if latched PAR_EN=1, else STOP.
- PARITY: mux_sel=11. par_bit is held stable for the whole frame. At end of bit, go to STOP.
- STOP: mux_sel=01, busy=1.
  - At end of bit, if DATA_VALID=1: latch new data and parameters exactly as in IDLE, go directly to START, keep busy=1 (back-to-back, no idle gap).
  - Otherwise go to IDLE, busy=0.
- DATA_VALID is ignored in START, DATA, PARITY and in STOP cycles other than the final one. Inputs P_DATA, PAR_EN, PAR_TYP and prescale may change freely while busy; latched values govern the frame.
- Frame length: (2 + DATA_WIDTH + latched PAR_EN) * latched prescale cycles.
- ser_data holds its last value outside DATA; the mux ignores it there.

Test Plan:
1. prescale=1, PAR_EN=1, PAR_TYP=0, P_DATA=0xA5, one-cycle DATA_VALID -> mux_sel sequence 00, 10x8, 11, 01. ser_data during DATA is 1,0,1,0,0,1,0,1. par_bit=0. busy high 11 cycles then 0.
2. prescale=1, PAR_EN=1, PAR_TYP=1, P_DATA=0x00 -> par_bit=1, ser_data all 0, 11-cycle frame.
3. prescale=4, PAR_EN=0, P_DATA=0x3C -> each mux_sel phase lasts 4 cycles, no 11 phase, frame 40 cycles. Toggling P_DATA and DATA_VALID mid-frame has no effect.
4. prescale=2, DATA_VALID held high, P_DATA=0x01 then 0x80 -> second frame START begins on the cycle after the first STOP ends. busy never drops. The second frame carries the data latched at the end of STOP.
5. Reset asserted in DATA bit 3 of a prescale=3 frame -> next edge gives mux_sel=01, busy=0, par_bit=0. A new DATA_VALID after reset release starts a full clean frame.
6. prescale=0, PAR_EN=1 -> behaves identically to prescale=1: one cycle per bit, 11-cycle frame.
